// File: rtl/mouse_tap_decoder.sv
// Receive-only PS/2 mouse front end: frame deserialiser, 3-byte packet assembly,
// clamped 640x480 cursor and one-hot hole taps on left-button press.
module mouse_tap_decoder #(
   parameter int unsigned FILT_LEN       = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned X_MAX          = 639,
   parameter int unsigned Y_MAX          = 479,
   parameter int unsigned X_INIT         = 320,
   parameter int unsigned Y_INIT         = 240
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [9:0] x,
   output logic [8:0] y,
   output logic       left,
   output logic       right,
   output logic       pkt_valid,
   output logic       click,
   output logic [7:0] tap,
   output logic       err
);

   localparam int unsigned FCW = $clog2(FILT_LEN + 1);
   localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic signed [10:0] XMaxS = 11'(X_MAX);
   localparam logic signed [10:0] YMaxS = 11'(Y_MAX);

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} frame_state_e;

   // ---------------------------------------------------------------------------
   // Input synchronisers and clock glitch filter
   // ---------------------------------------------------------------------------
   logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic           filt_q;
   logic [FCW-1:0] filt_cnt_q;
   logic           filt_flip, strobe;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
      end
   end

   // Flip on the FILT_LEN-th consecutive sample that disagrees with the filtered level
   assign filt_flip = (clk_s2_q != filt_q) && (filt_cnt_q == FCW'(FILT_LEN - 1));
   assign strobe    = filt_flip && filt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
      end else if (clk_s2_q == filt_q) begin
         filt_cnt_q <= '0;
      end else if (filt_flip) begin
         filt_q     <= ~filt_q;
         filt_cnt_q <= '0;
      end else begin
         filt_cnt_q <= filt_cnt_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------------------
   frame_state_e   state_q, state_d;
   logic [7:0]     shift_q;
   logic [2:0]     bit_cnt_q;
   logic           par_q;
   logic [TCW-1:0] to_cnt_q;
   logic           timeout, frame_ok, frame_bad;

   assign timeout = (state_q != StIdle) && !strobe && (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d   = state_q;
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
      if (timeout) begin
         state_d   = StIdle;
         frame_bad = 1'b1;
      end else if (strobe) begin
         unique case (state_q)
            StIdle:   if (!dat_s2_q) state_d = StData;
            StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
            StParity: state_d = StStop;
            StStop: begin
               state_d = StIdle;
               if (dat_s2_q && (^{shift_q, par_q})) frame_ok = 1'b1;
               else frame_bad = 1'b1;
            end
            default:  state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         par_q     <= 1'b0;
         to_cnt_q  <= '0;
      end else begin
         state_q <= state_d;
         if (strobe || state_q == StIdle) to_cnt_q <= '0;
         else to_cnt_q <= to_cnt_q + 1'b1;
         if (strobe) begin
            case (state_q)
               StIdle:   bit_cnt_q <= '0;
               StData: begin
                  shift_q   <= {dat_s2_q, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
               StParity: par_q <= dat_s2_q;
               default:  ;
            endcase
         end
      end
   end

   // Frame result registered once; packet logic acts on it the following cycle
   logic       byte_vld_q, frame_err_q;
   logic [7:0] byte_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_vld_q  <= 1'b0;
         frame_err_q <= 1'b0;
         byte_q      <= '0;
      end else begin
         byte_vld_q  <= frame_ok;
         frame_err_q <= frame_bad;
         if (frame_ok) byte_q <= shift_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Packet assembly and cursor update
   // ---------------------------------------------------------------------------
   logic [1:0]         idx_q;
   logic [7:0]         b0_q, b1_q;
   logic signed [10:0] dx, dy, x_sum, y_sum;
   logic [9:0]         x_new;
   logic [8:0]         y_new;
   logic [1:0]         col;
   logic               row, click_new;
   logic [7:0]         tap_new;

   always_comb begin
      dx    = b0_q[6] ? 11'sd0 : {{3{b0_q[4]}}, b1_q};
      dy    = b0_q[7] ? 11'sd0 : {{3{b0_q[5]}}, byte_q};
      x_sum = $signed({1'b0, x}) + dx;
      y_sum = $signed({2'b00, y}) - dy;  // PS/2 +dy is up, screen y grows down

      if (x_sum < 11'sd0)      x_new = '0;
      else if (x_sum > XMaxS)  x_new = 10'(X_MAX);
      else                     x_new = x_sum[9:0];

      if (y_sum < 11'sd0)      y_new = '0;
      else if (y_sum > YMaxS)  y_new = 9'(Y_MAX);
      else                     y_new = y_sum[8:0];

      if (x_new < 10'd160)      col = 2'd0;
      else if (x_new < 10'd320) col = 2'd1;
      else if (x_new < 10'd480) col = 2'd2;
      else                      col = 2'd3;
      row = (y_new >= 9'd240);

      click_new = b0_q[0] & ~left;
      tap_new   = click_new ? (8'b1 << {row, col}) : 8'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x         <= 10'(X_INIT);
         y         <= 9'(Y_INIT);
         left      <= 1'b0;
         right     <= 1'b0;
         pkt_valid <= 1'b0;
         click     <= 1'b0;
         tap       <= '0;
         err       <= 1'b0;
         idx_q     <= '0;
         b0_q      <= '0;
         b1_q      <= '0;
      end else begin
         pkt_valid <= 1'b0;
         click     <= 1'b0;
         tap       <= '0;
         err       <= 1'b0;
         if (frame_err_q) begin
            err   <= 1'b1;
            idx_q <= '0;
         end else if (byte_vld_q) begin
            case (idx_q)
               2'd0: begin
                  // Bit 3 is always set in a header byte; anything else means we lost sync
                  if (byte_q[3]) begin
                     b0_q  <= byte_q;
                     idx_q <= 2'd1;
                  end else begin
                     err <= 1'b1;
                  end
               end
               2'd1: begin
                  b1_q  <= byte_q;
                  idx_q <= 2'd2;
               end
               default: begin
                  x         <= x_new;
                  y         <= y_new;
                  left      <= b0_q[0];
                  right     <= b0_q[1];
                  pkt_valid <= 1'b1;
                  click     <= click_new;
                  tap       <= tap_new;
                  idx_q     <= 2'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/mouse_tap_decoder.md
Name: mouse_tap_decoder

Overview:
- Receive-only PS/2 mouse front end that feeds the whack-a-mole game logic.
- Deserialises 11-bit PS/2 frames and assembles 3-byte movement packets.
- Maintains a clamped 640x480 cursor and emits a one-cycle one-hot tap[7:0] when the left button is pressed over one of 8 hole regions.
- Enabling streaming (0xF4) is outside this block; the mouse is already streaming.

Parameters:
- FILT_LEN, 8: consecutive identical samples required before filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 100000: clk cycles without a falling edge, mid-frame, before the frame is aborted (1 ms at 100 MHz).
- X_MAX, 639: cursor x upper bound.
- Y_MAX, 479: cursor y upper bound.
- X_INIT, 320: cursor x reset value.
- Y_INIT, 240: cursor y reset value.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high reset
- ps2_clk  input  1  raw PS/2 clock from pin, asynchronous
- ps2_data  input  1  raw PS/2 data from pin, asynchronous
- x  output  10  cursor x, 0..X_MAX
- y  output  9  cursor y, 0..Y_MAX
- left  output  1  left button state from last accepted packet
- right  output  1  right button state from last accepted packet
- pkt_valid  output  1  one-cycle pulse per accepted packet
- click  output  1  one-cycle pulse on left-button 0->1
- tap  output  8  one-hot, one-cycle hole hit; 0 otherwise
- err  output  1  one-cycle pulse on frame or packet error

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: x=X_INIT, y=Y_INIT; left, right, pkt_valid, click, tap, err all 0. FSM goes to IDLE, byte index to 0, filter to 1.
- Reset mid-frame or mid-packet discards all partial data.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - Filtered clock changes level only after FILT_LEN equal consecutive synchronised samples.
  - A filtered 1->0 transition is a sample strobe; data is taken from the synchronised ps2_data in the same cycle.
- Frame FSM, advanced on strobes:
  - IDLE: a strobe with data=0 (start bit) goes to DATA; data=1 is ignored.
  - DATA: 8 bits, LSB first, then PARITY.
  - PARITY: captures the parity bit, then STOP.
  - STOP: stop bit must be 1, and XOR of 8 data bits and parity must be 1 (odd parity). Pass delivers the byte; fail pulses err, resets byte index to 0, returns to IDLE.
- Timeout: in DATA, PARITY or STOP, TIMEOUT_CYCLES clk cycles with no strobe aborts the frame. Result: IDLE, err pulse, byte index 0. The counter restarts on every strobe.
- Packet assembly:
  - Byte 0 must have bit3=1. If not, discard it, pulse err, keep index 0 (resync).
  - Byte 0 fields: bit0 left, bit1 right, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
  - dx = {Xsign, byte1}, dy = {Ysign, byte2}, both 9-bit two's complement.
  - If an axis overflow bit is set, that axis delta is 0.
- Cursor update, on byte-2 delivery:
  - x_new = clamp(x + dx, 0, X_MAX).
  - y_new = clamp(y - dy, 0, Y_MAX); PS/2 +dy is up, screen y grows down.
  - Arithmetic is 11-bit signed; no wrap-around.
- Latency: x, y, left, right, pkt_valid, click and tap all update on the clk edge after the edge that samples byte 2's stop bit.
- click = left_new & ~left_old, asserted in the same cycle as pkt_valid.
- tap:
  - Asserted only when click is asserted, and uses x_new and y_new.
  - col = x_new/160 (0..3); row = 1 if y_new >= 240, else 0.
  - tap[row*4+col] = 1 for that cycle; all bits 0 on every other cycle.
- err and pkt_valid never assert in the same cycle. After any error the next valid 3-byte packet is accepted normally.

Test Plan:
- Reset held 3 cycles -> x=320, y=240, left=0, tap=0, err=0.
- Frames 0x08, 0x0A, 0x05 -> one pkt_valid pulse; x=330, y=235; click=0, tap=0.
- Then 0x09, 0x00, 0x00 -> click pulse, tap=8'b0000_0100 (col 2, row 0), left=1. Repeat the same packet -> left stays 1, no click, tap=0.
- Packet 0x18, 0x00, 0x00 (dx=-256) from x=330 -> x=74; again -> x=0 (clamped). Then 0x28, 0x00, 0x00 (dy=-256) from y=235 -> y=479 (clamped).
- Axis overflow and framing errors:
  - Byte 0 = 0x48 with byte 1 = 0x7F -> x unchanged.
  - Byte 1 sent with wrong parity -> err pulse, no pkt_valid; the next valid packet is accepted.
  - Byte 0 with bit3=0 -> err, resync.
- 5 bits of a frame then idle for 100000 cycles -> err pulse, FSM back to IDLE. ps2_clk low glitches shorter than 8 cycles -> no strobe, no state change.
